pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline stage register for the processor datapath, the successor to the fixed EX/MEM register. It carries a generic data word plus a control word between two stages under a valid/ready handshake, with a two-entry skid buffer so that stalls do not combinationally couple `in_ready` to `out_ready`. It supports flush with bubble insertion, forces a configurable safe control pattern whenever the output is invalid, and keeps a saturating stall-cycle counter for performance debug. One instance is placed at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 135 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with a two-entry skid buffer, flush/bubble
// insertion, safe-control forcing on invalid output and a saturating stall counter.
module pipe_stage_reg #(
    parameter int unsigned                DATA_WIDTH  = 32,
    parameter int unsigned                CTRL_WIDTH  = 8,
    parameter logic [CTRL_WIDTH-1:0]      CTRL_BUBBLE = '0,
    parameter int unsigned                CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    state_t                stateNext;
    logic [DATA_WIDTH-1:0] mData;
    logic [CTRL_WIDTH-1:0] mCtrl;
    logic [DATA_WIDTH-1:0] sData;
    logic [CTRL_WIDTH-1:0] sCtrl;
    logic [CNT_WIDTH-1:0]  stallCount;
    logic                  accept;
    logic                  take;
    logic                  loadMIn;
    logic                  loadMSkid;
    logic                  loadS;

    assign accept = in_valid & in_ready & ~flush;
    assign take   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // Load enables are decoded alongside the next state so the datapath follows the FSM exactly.
    always_comb begin
        stateNext = state;
        loadMIn   = 1'b0;
        loadMSkid = 1'b0;
        loadS     = 1'b0;
        if (flush) begin
            stateNext = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        stateNext = ONE;
                        loadMIn   = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        loadMIn = 1'b1;
                    end else if (accept) begin
                        stateNext = TWO;
                        loadS     = 1'b1;
                    end else if (take) begin
                        stateNext = EMPTY;
                    end
                end
                TWO: begin
                    if (take) begin
                        stateNext = ONE;
                        loadMSkid = 1'b1;
                    end
                end
                default: stateNext = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state != TWO);
        out_valid = (state != EMPTY);
        out_data  = mData;
        out_ctrl  = out_valid ? mCtrl : CTRL_BUBBLE;
        unique case (state)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mData <= '0;
            mCtrl <= '0;
            sData <= '0;
            sCtrl <= '0;
        end else begin
            if (loadMIn) begin
                mData <= in_data;
                mCtrl <= in_ctrl;
            end else if (loadMSkid) begin
                mData <= sData;
                mCtrl <= sCtrl;
            end
            if (loadS) begin
                sData <= in_data;
                sCtrl <= in_ctrl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
        end else if (out_valid && !out_ready && (stallCount != '1)) begin
            stallCount <= stallCount + 1'b1;
        end
    end

    assign stall_count = stallCount;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized bench for pipe_stage_reg against a queue-based
// reference model of the stage contents and stall counter.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam int unsigned NW = 4;
    localparam logic [CW-1:0] BUBBLE = 8'h5A;
    localparam int SAT = (1 << NW) - 1;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_count;

    pipe_stage_reg #(
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CW),
        .CTRL_BUBBLE(BUBBLE),
        .CNT_WIDTH  (NW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .occupancy  (occupancy),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: beats held in acceptance order ({data, ctrl}) and the stall count.
    logic [DW+CW-1:0] q[$];
    int               cnt   = 0;
    bit               known = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compareModel();
        check("in_ready", 64'(in_ready), 64'(q.size() < 2));
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("occupancy", 64'(occupancy), 64'(q.size()));
        check("stall_count", 64'(stall_count), 64'(cnt));
        if (q.size() > 0) begin
            check("out_data", 64'(out_data), 64'(q[0][DW+CW-1:CW]));
            check("out_ctrl", 64'(out_ctrl), 64'(q[0][CW-1:0]));
        end else begin
            check("out_ctrl_bubble", 64'(out_ctrl), 64'(BUBBLE));
        end
    endtask

    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ordy);
        bit doTake;
        bit doAccept;
        bit stalled;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        #1;
        if (known) compareModel();
        doTake   = (q.size() > 0) && ordy;
        doAccept = iv && (q.size() < 2) && !fl;
        stalled  = (q.size() > 0) && !ordy;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            cnt   = 0;
            known = 1;
        end else begin
            if (stalled && cnt < SAT) cnt++;
            if (doTake) void'(q.pop_front());
            if (fl) q.delete();
            if (doAccept) q.push_back({d, c});
        end
    endtask

    initial begin
        // Reset held two cycles with a beat offered.
        step(1, 0, 1, 32'hDEAD, 8'h11, 0);
        step(1, 0, 1, 32'hDEAD, 8'h11, 0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'(BUBBLE));
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_stall", 64'(stall_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);

        // Streaming 1..8 with downstream always ready.
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1, 32'(i), 8'(i + 8'h80), 1);
            check("stream_data", 64'(out_data), 64'(i));
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        step(0, 0, 0, '0, '0, 1);
        step(0, 0, 0, '0, '0, 1);
        check("stream_stall", 64'(stall_count), 64'd0);

        // Skid: two beats into a stalled stage, then drain.
        step(0, 0, 1, 32'h10, 8'h01, 0);
        step(0, 0, 1, 32'h20, 8'h02, 0);
        check("skid_occ", 64'(occupancy), 64'd2);
        check("skid_in_ready", 64'(in_ready), 64'd0);
        check("skid_head", 64'(out_data), 64'h10);
        step(0, 0, 0, '0, '0, 0);
        step(0, 0, 0, '0, '0, 1);
        check("skid_second", 64'(out_data), 64'h20);
        check("skid_recover", 64'(in_ready), 64'd1);
        check("skid_stall", 64'(stall_count), 64'd2);
        step(0, 0, 0, '0, '0, 1);
        check("skid_empty", 64'(occupancy), 64'd0);

        // Flush while holding two beats, with a new beat offered.
        step(0, 0, 1, 32'hA1, 8'h03, 0);
        step(0, 0, 1, 32'hA2, 8'h04, 0);
        check("flush_pre_occ", 64'(occupancy), 64'd2);
        step(0, 1, 1, 32'h30, 8'h05, 0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ctrl", 64'(out_ctrl), 64'(BUBBLE));
        check("flush_occ", 64'(occupancy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, '0, '0, 1);
            check("flush_no_0x30", 64'(out_valid), 64'd0);
        end

        // Saturation of the 4-bit stall counter.
        step(1, 0, 0, '0, '0, 0);
        step(0, 0, 1, 32'h77, 8'h06, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, '0, '0, 0);
        check("sat_stall", 64'(stall_count), 64'(SAT));
        step(0, 0, 0, '0, '0, 0);
        check("sat_hold", 64'(stall_count), 64'(SAT));
        check("sat_data", 64'(out_data), 64'h77);

        // Randomized traffic with sporadic flushes and rare resets.
        step(1, 0, 0, '0, '0, 0);
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0), $urandom, 8'($urandom),
                 ($urandom_range(0, 9) < 7));
        end
        step(0, 0, 0, '0, '0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
